// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared FSM state encoding and datapath widths for the memory stage.
package mem_stage_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  localparam int WORD_W = 32;
  localparam int REG_W = 4;
endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: BUSY wait counter; clr zeroes it, en counts a no-ack cycle,
// expire flags the counting cycle that reaches LIMIT.
// Ports: clk, rst_n (async, active-low), clr, en, expire.
module mem_timeout_ctr #(
  parameter int LIMIT = 15,
  parameter int W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign expire = en & (cnt == W'(LIMIT - 1));
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage; passes ALU results through in one cycle and runs
// loads/stores as a stalled IDLE/BUSY handshake with dmem, aborting after TIMEOUT_CYCLES.
// Ports: clk, rst_n (async, active-low); EX/MEM bundle valid_in, MReg_in, MR_in, MW_in,
// EnRW_in, ALU_out_in, rd2_in, reg_rd_in; stall_out; dmem_req/we/addr/wdata/rdata/ack;
// MEM/WB wb_valid, wb_we, wb_data, wb_rd; mem_err pulse.
// Option: define MEM_MISALIGN_TRAP_EN to trap memory ops with ALU_out_in[1:0] != 0.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              MReg_in,
  input  logic              MR_in,
  input  logic              MW_in,
  input  logic              EnRW_in,
  input  logic [WORD_W-1:0] ALU_out_in,
  input  logic [WORD_W-1:0] rd2_in,
  input  logic [REG_W-1:0]  reg_rd_in,
  output logic              stall_out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [WORD_W-1:0] dmem_addr,
  output logic [WORD_W-1:0] dmem_wdata,
  input  logic [WORD_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [WORD_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_rd,
  output logic              mem_err
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1) > 4 ? $clog2(TIMEOUT_CYCLES + 1) : 4;
  state_t state, state_nxt;
  logic idle, busy, plain, mem_op, mis, start, done, expire, reject;
  logic op_w, mreg_q, enrw_q;
  logic [REG_W-1:0] rd_q;
  logic wbv_nxt, wbwe_nxt, err_nxt;
  logic [WORD_W-1:0] wbdata_nxt;
  logic [REG_W-1:0] wbrd_nxt;
`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = |ALU_out_in[1:0];
`else
  assign mis = 1'b0;
`endif
  assign idle = state == IDLE;
  assign busy = state == BUSY;
  assign mem_op = MR_in ^ MW_in;
  assign plain = valid_in & ~MR_in & ~MW_in;
  assign start = idle & valid_in & mem_op & ~mis;
  assign done = busy & dmem_ack;
  // accepted in IDLE without an access: MR&MW both set, or a trapped misaligned op
  assign reject = idle & valid_in & ~plain & ~start;
  // counting only on no-ack BUSY cycles makes a same-cycle ack win over expiry
  mem_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES), .W(CNT_W)) u_ctr (
    .clk(clk), .rst_n(rst_n), .clr(idle), .en(busy & ~dmem_ack), .expire(expire)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = idle ? (start ? BUSY : IDLE) : ((dmem_ack | expire) ? IDLE : BUSY);
  always_comb begin
    stall_out = rst_n & (start | (busy & ~dmem_ack));
    dmem_req = busy;
    dmem_we = busy & op_w;
    wbv_nxt = (idle & valid_in & ~start) | done | expire;
    wbwe_nxt = idle ? plain & EnRW_in : done & ~op_w & enrw_q;
    wbdata_nxt = (idle & plain) ? ALU_out_in :
                 done ? ((~op_w & mreg_q) ? dmem_rdata : dmem_addr) : wb_data;
    wbrd_nxt = (idle & valid_in & ~start) ? reg_rd_in : (done | expire) ? rd_q : wb_rd;
    err_nxt = reject | expire;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dmem_addr <= '0;
      dmem_wdata <= '0;
      rd_q <= '0;
      op_w <= 1'b0;
      mreg_q <= 1'b0;
      enrw_q <= 1'b0;
      wb_valid <= 1'b0;
      wb_we <= 1'b0;
      wb_data <= '0;
      wb_rd <= '0;
      mem_err <= 1'b0;
    end else begin
      if (start) begin
        dmem_addr <= {ALU_out_in[WORD_W-1:2], 2'b00};
        dmem_wdata <= rd2_in;
        rd_q <= reg_rd_in;
        op_w <= MW_in;
        mreg_q <= MReg_in;
        enrw_q <= EnRW_in;
      end
      wb_valid <= wbv_nxt;
      wb_we <= wbwe_nxt;
      wb_data <= wbdata_nxt;
      wb_rd <= wbrd_nxt;
      mem_err <= err_nxt;
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed table vectors for single-cycle behaviour plus hand sequences for memory handshakes.
module tb_mem_stage;
  logic clk = 0, rst_n = 1;
  logic valid_in, MReg_in, MR_in, MW_in, EnRW_in, dmem_ack;
  logic [31:0] ALU_out_in, rd2_in, dmem_rdata;
  logic [3:0] reg_rd_in;
  logic stall_out, dmem_req, dmem_we, wb_valid, wb_we, mem_err;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0] wb_rd;
  logic [38:0] wbo;
  int total = 0, passed = 0;

  typedef struct packed {
    logic valid, mr, mw, enrw, ack;
    logic [31:0] alu;
    logic [3:0] rd;
    logic stall;
    logic [38:0] exp;
  } vec_t;
  vec_t tv[7];

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .MReg_in(MReg_in), .MR_in(MR_in),
    .MW_in(MW_in), .EnRW_in(EnRW_in), .ALU_out_in(ALU_out_in), .rd2_in(rd2_in),
    .reg_rd_in(reg_rd_in), .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .wb_valid(wb_valid), .wb_we(wb_we), .wb_data(wb_data),
    .wb_rd(wb_rd), .mem_err(mem_err)
  );

  assign wbo = {wb_valid, wb_we, wb_data, wb_rd, mem_err};

  function automatic logic [38:0] wbx(input logic v, we, input logic [31:0] d,
                                      input logic [3:0] rd, input logic err);
    return {v, we, d, rd, err};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    valid_in = 0; MR_in = 0; MW_in = 0; MReg_in = 0; EnRW_in = 0; dmem_ack = 0;
    ALU_out_in = 0; rd2_in = 0; reg_rd_in = 0;
  endtask

  task automatic mem(input logic mr, mw, mreg, enrw, input logic [31:0] a, d, input logic [3:0] rd);
    valid_in = 1; MR_in = mr; MW_in = mw; MReg_in = mreg; EnRW_in = enrw; dmem_ack = 0;
    ALU_out_in = a; rd2_in = d; reg_rd_in = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    tv[0] = '{1, 0, 0, 1, 0, 32'h0000_00A5, 4'd3, 0, wbx(1, 1, 32'hA5, 3, 0)};
    tv[1] = '{0, 0, 0, 0, 0, 32'h0, 4'd0, 0, wbx(0, 0, 32'hA5, 3, 0)};
    tv[2] = '{1, 0, 0, 0, 0, 32'h1234_5678, 4'd7, 0, wbx(1, 0, 32'h1234_5678, 7, 0)};
    tv[3] = '{1, 1, 1, 1, 0, 32'h40, 4'd5, 0, wbx(1, 0, 32'h1234_5678, 5, 1)};
    tv[4] = '{0, 0, 0, 0, 1, 32'h0, 4'd0, 0, wbx(0, 0, 32'h1234_5678, 5, 0)};
    tv[5] = '{1, 0, 0, 1, 0, 32'hFFFF_FFFF, 4'd15, 0, wbx(1, 1, 32'hFFFF_FFFF, 15, 0)};
    tv[6] = '{1, 0, 0, 1, 1, 32'h0, 4'd0, 0, wbx(1, 1, 32'h0, 0, 0)};
    idle_in;
    dmem_rdata = 0;
    #1 rst_n = 0;
    valid_in = 1; MR_in = 1;
    #1;
    chk("reset_stall", stall_out, 0);
    chk("reset_wb", wbo, 0);
    chk("reset_dmem", {dmem_req, dmem_we, dmem_addr, dmem_wdata}, 0);
    idle_in;
    tick;
    tick;
    rst_n = 1;
    tick;

    for (int i = 0; i < 7; i++) begin
      valid_in = tv[i].valid; MR_in = tv[i].mr; MW_in = tv[i].mw; EnRW_in = tv[i].enrw;
      dmem_ack = tv[i].ack; ALU_out_in = tv[i].alu; reg_rd_in = tv[i].rd; MReg_in = 0;
      #1;
      chk($sformatf("vec%0d_stall", i), {stall_out, dmem_req}, {tv[i].stall, 1'b0});
      tick;
      chk($sformatf("vec%0d_wb", i), wbo, tv[i].exp);
    end
    idle_in;

    mem(1, 0, 1, 1, 32'h100, 0, 9);
    #1 chk("ld_stall0", {stall_out, dmem_req}, 2'b10);
    tick;
    idle_in;
    #1 chk("ld_busy1", {stall_out, dmem_req, dmem_we, dmem_addr}, {3'b110, 32'h100});
    chk("ld_busy1_wbv", wb_valid, 0);
    tick;
    chk("ld_busy2", {stall_out, dmem_req}, 2'b11);
    dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
    #1 chk("ld_busy3_stall", stall_out, 0);
    tick;
    idle_in;
    chk("ld_wb", wbo, wbx(1, 1, 32'hDEAD_BEEF, 9, 0));
    chk("ld_req_drop", dmem_req, 0);
    tick;
    chk("ld_wbv_once", {wb_valid, mem_err}, 0);

    mem(0, 1, 0, 1, 32'h200, 32'h1234, 4);
    #1 chk("st_stall0", stall_out, 1);
    tick;
    idle_in;
    dmem_ack = 1;
    #1 chk("st_busy1", {stall_out, dmem_req, dmem_we, dmem_addr, dmem_wdata},
           {3'b011, 32'h200, 32'h1234});
    tick;
    idle_in;
    chk("st_wb", wbo, wbx(1, 0, 32'h200, 4, 0));

    mem(1, 0, 0, 1, 32'h300, 0, 6);
    tick;
    idle_in;
    dmem_ack = 1; dmem_rdata = 32'h77;
    tick;
    idle_in;
    chk("ld_nomreg_wb", wbo, wbx(1, 1, 32'h300, 6, 0));

    mem(1, 0, 1, 1, 32'h400, 0, 2);
    tick;
    idle_in;
    for (int k = 1; k <= 14; k++) begin
      chk($sformatf("to_busy%0d", k), {dmem_req, stall_out, mem_err}, 3'b110);
      tick;
    end
    chk("to_busy15", {dmem_req, stall_out, mem_err}, 3'b110);
    tick;
    chk("to_wb", wbo, wbx(1, 0, 32'h300, 2, 1));
    chk("to_req_drop", {dmem_req, stall_out}, 0);
    tick;
    chk("to_err_once", {wb_valid, mem_err}, 0);

    mem(1, 0, 1, 1, 32'h500, 0, 11);
    tick;
    idle_in;
    repeat (14) tick;
    dmem_ack = 1; dmem_rdata = 32'hCAFE_0000;
    tick;
    idle_in;
    chk("ack_at_limit", wbo, wbx(1, 1, 32'hCAFE_0000, 11, 0));

    mem(1, 0, 1, 1, 32'h600, 0, 12);
    tick;
    idle_in;
    tick;
    valid_in = 1; MR_in = 1;
    rst_n = 0;
    #1 chk("rst_busy_out", {dmem_req, stall_out}, 0);
    chk("rst_busy_wb", wbo, 0);
    dmem_ack = 1;
    tick;
    rst_n = 1;
    idle_in;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk($sformatf("rst_after%0d", k), {wb_valid, mem_err, dmem_req}, 0);
    end

    mem(1, 0, 1, 1, 32'h102, 0, 13);
`ifdef MEM_MISALIGN_TRAP_EN
    #1 chk("mis_no_req", {stall_out, dmem_req}, 0);
    tick;
    idle_in;
    chk("mis_wb", wbo, wbx(1, 0, 32'h0, 13, 1));
    chk("mis_req", dmem_req, 0);
`else
    #1 chk("mis_stall", stall_out, 1);
    tick;
    idle_in;
    chk("mis_addr", {dmem_req, dmem_addr}, {1'b1, 32'h100});
    dmem_ack = 1; dmem_rdata = 32'h55;
    tick;
    idle_in;
    chk("mis_wb", wbo, wbx(1, 1, 32'h55, 13, 0));
`endif
    tick;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15: maximum BUSY cycles spent waiting for dmem_ack before abort.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 valid_in  input  1  EX/MEM bundle valid this cycle.
REQ-005 MReg_in, MR_in, MW_in, EnRW_in  input  1 each  writeback-select-memory, mem-read, mem-write, register-write-enable.
REQ-006 ALU_out_in, rd2_in  input  32 each  memory address or ALU result; store data.
REQ-007 reg_rd_in  input  4  destination register index.
REQ-008 stall_out  output  1  holds the EX/MEM register and upstream stages.
REQ-009 dmem_req, dmem_we  output  1 each  memory request, write strobe.
REQ-010 dmem_addr, dmem_wdata  output  32 each  word address, store data.
REQ-011 dmem_rdata  input  32  load data; dmem_ack  input  1  access complete.
REQ-012 wb_valid, wb_we  output  1 each  MEM/WB valid, register write enable.
REQ-013 wb_data  output  32; wb_rd  output  4; mem_err  output  1  one-cycle error pulse.

Function
REQ-014 FSM states: IDLE, BUSY; encoding in shared package.
REQ-015 IDLE, valid_in with MR_in=MW_in=0: next edge wb_valid=1, wb_data=ALU_out_in, wb_rd=reg_rd_in, wb_we=EnRW_in; latency 1; stall_out=0.
REQ-016 IDLE, valid_in with exactly one of MR_in/MW_in: stall_out=1 combinationally same cycle; next edge captures addr, wdata, rd, MReg, EnRW, op; enters BUSY; wb_valid=0.
REQ-017 BUSY: dmem_req=1, dmem_we=captured MW, dmem_addr/dmem_wdata stable until exit; dmem_ack may arrive in first BUSY cycle.
REQ-018 BUSY and dmem_ack: stall_out=0 that cycle; next edge returns IDLE, wb_valid=1, wb_rd=captured rd.
REQ-019 On ack: load -> wb_data=dmem_rdata if captured MReg=1, else captured address; wb_we=captured EnRW; store -> wb_we=0, wb_data=captured address.
REQ-020 BUSY, no ack: stall_out=1; 4-bit-minimum wait counter increments; cleared on BUSY entry.
REQ-021 Counter reaching TIMEOUT_CYCLES without ack: dmem_req drops, mem_err=1 one cycle, wb_valid=1 with wb_we=0, return IDLE.
REQ-022 Ack in the same cycle as counter reaching TIMEOUT_CYCLES: ack wins, no mem_err.
REQ-023 valid_in with MR_in=MW_in=1: no memory access, mem_err=1, wb_valid=1, wb_we=0, stays IDLE.
REQ-024 valid_in=0 in IDLE: wb_valid=0 next edge; wb_data, wb_rd hold.
REQ-025 dmem_ack while IDLE: ignored.
REQ-026 mem_err, wb_valid never asserted more than one cycle per accepted bundle.

Reset
REQ-027 rst_n low: immediately state=IDLE, counter=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, wb_valid=0, wb_we=0, wb_data=0, wb_rd=0, mem_err=0.
REQ-028 stall_out=0 while rst_n low.
REQ-029 Reset during BUSY: request abandoned without mem_err or wb_valid.

Configuration
REQ-030 Macro MEM_MISALIGN_TRAP_EN defined: memory op with ALU_out_in[1:0]!=0 raises no request, mem_err=1, wb_valid=1, wb_we=0, stays IDLE.
REQ-031 Macro undefined: dmem_addr = {ALU_out_in[31:2],2'b00}, access proceeds normally, no error.

Structure
REQ-032 Shared package: FSM state typedef, 32-bit word width constant, 4-bit register index width constant.
REQ-033 One sub-module, mem_timeout_ctr: wait counter with clear, enable, expire output.

Verification
REQ-034 ALU op, ALU_out_in=0x0000_00A5, rd=3, EnRW=1 -> next cycle wb_valid=1, wb_data=0xA5, wb_rd=3, stall_out never 1.
REQ-035 Load addr 0x100, MReg=1, ack after 2 BUSY cycles with rdata 0xDEADBEEF -> stall_out high 3 cycles, then wb_data=0xDEADBEEF, wb_we=1.
REQ-036 Store addr 0x200, rd2=0x1234, ack in first BUSY cycle -> dmem_we=1, dmem_wdata=0x1234, wb_we=0.
REQ-037 Load, ack never asserted, TIMEOUT_CYCLES=15 -> mem_err pulse after 15 BUSY cycles, dmem_req=0, wb_we=0.
REQ-038 rst_n low in second BUSY cycle -> dmem_req=0 and stall_out=0 immediately, no wb_valid afterwards.
REQ-039 MEM_MISALIGN_TRAP_EN defined, load addr 0x102 -> no dmem_req, mem_err=1, wb_valid=1, wb_we=0.
